// File: rtl/div_pkg.sv
// Shared constants and types for the 30-by-4 sequential restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    localparam int QW = 26;          // quotient width
    localparam int DW = 4;           // divisor / remainder width
    localparam int PW = QW + DW;     // dividend width
    localparam int CW = $clog2(QW);  // bit-index counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The quotient only fits in QW bits when the dividend's top DW bits
    // are strictly below the divisor.
    function automatic logic quot_overflows(input logic [PW-1:0] p, input logic [DW-1:0] y);
        return (y != '0) && (p[PW-1:QW] >= y);
    endfunction

endpackage

// File: rtl/mult_26x4.sv
// Unsigned 26x4 product used to re-multiply the divider's result.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_a (26b multiplicand), i_b (4b multiplier), o_p (30b product).
// Only compiled when DIV_30X4_SELFCHECK_EN is defined.
`ifdef DIV_30X4_SELFCHECK_EN
module mult_26x4
    import div_pkg::*;
(
    input  logic [QW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [PW-1:0] o_p
);

    assign o_p = PW'(i_a) * PW'(i_b);

endmodule
`endif

// File: rtl/div_30x4_seq.sv
// Radix-2 restoring divider: 30-bit dividend / 4-bit divisor -> 26-bit quotient, 4-bit remainder.
// Latency: out_valid 27 cycles after the accepting edge; 1 cycle for divide-by-zero/overflow.
// Backpressure: one op in flight; in_ready only in IDLE; DONE holds outputs until out_ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     dividend handshake; in_p (30b) dividend, in_y (4b) divisor
//   out_valid/out_ready   result handshake; out_q (26b), out_r (4b), out_dbz, out_ovf
//   out_chk_err           (DIV_30X4_SELFCHECK_EN only) q*y+r != p on a normal result
//
// Optional feature macro: DIV_30X4_SELFCHECK_EN.
module div_30x4_seq
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_p,
    input  logic [DW-1:0] in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_q,
    output logic [DW-1:0] out_r,
    output logic          out_dbz,
    output logic          out_ovf
`ifdef DIV_30X4_SELFCHECK_EN
    ,
    output logic          out_chk_err
`endif
);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_p;
    logic [DW-1:0] r_y;
    logic [DW-1:0] r_rem;
    logic [QW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_dbz;
    logic          w_ovf;
    logic          w_err;
    logic [DW:0]   w_t;
    logic          w_ge;
    logic [DW-1:0] w_sub;

    assign w_dbz = (in_y == '0);
    assign w_ovf = quot_overflows(in_p, in_y);
    assign w_err = w_dbz | w_ovf;

    // Partial remainder shifted left with the next dividend bit. Since
    // rem < y holds entering every step, t < 2y and at most one subtract
    // is needed; the DW-bit difference is exact whenever t >= y.
    assign w_t   = {r_rem, r_p[r_cnt]};
    assign w_ge  = (w_t >= {1'b0, r_y});
    assign w_sub = w_t[DW-1:0] - r_y;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = w_err ? DONE : RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_y   <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_p   <= in_p;
                        r_y   <= in_y;
                        r_dbz <= w_dbz;
                        r_ovf <= w_ovf;
                        r_cnt <= CW'(QW - 1);
                        if (w_dbz) begin
                            r_q   <= '1;
                            r_rem <= in_p[DW-1:0];
                        end else if (w_ovf) begin
                            r_q   <= '1;
                            r_rem <= '0;
                        end else begin
                            // Top DW bits are already below y: seed the remainder.
                            r_q   <= '0;
                            r_rem <= in_p[PW-1:QW];
                        end
                    end
                end
                RUN: begin
                    // Quotient bits arrive MSB first, so shifting left
                    // lands bit cnt in position cnt after the last step.
                    r_rem <= w_ge ? w_sub : w_t[DW-1:0];
                    r_q   <= {r_q[QW-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_q   = r_q;
    assign out_r   = r_rem;
    assign out_dbz = r_dbz;
    assign out_ovf = r_ovf;

`ifdef DIV_30X4_SELFCHECK_EN
    logic [PW-1:0] w_prod;

    mult_26x4 u_mult (
        .i_a (r_q),
        .i_b (r_y),
        .o_p (w_prod)
    );

    // Error results carry saturated quotients by design; only normal
    // results are required to reconstruct the dividend.
    assign out_chk_err = (r_state == DONE) && !r_dbz && !r_ovf &&
                         ((w_prod + PW'(r_rem)) != r_p);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!out_chk_err);
        end
    end
`endif

endmodule
